fetch_ctrl: RTL and testbench

Sequencer for the instruction fetch path: owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and holds each returned instruction in a single-entry output buffer until decode accepts it. Redirects (branch/jump targets) can arrive in any state. Responses already in flight when a redirect arrives are discarded, so decode only ever sees instructions on the current path. Sits between the instruction memory port and decode, replacing the free-running PC counter.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_buf.sv | 29 ++
 rtl/fetch_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DRAIN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry valid/ready holding register; flush drops the held entry but keeps the data.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic         ready,
  input  logic [W-1:0] data,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (flush || ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, one outstanding imem request, single-entry output buffer.
// Optional misaligned-redirect trap enabled by FETCH_CTRL_MISALIGN_TRAP_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        AWIDTH   = 32,
  parameter int unsigned        DWIDTH   = 32,
  parameter logic [AWIDTH-1:0]  BASEADDR = AWIDTH'(32'h01000000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic              misalign_o
);

  fetch_state_e      state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, tgt_c;
  logic              mis_q, mis_d, req_valid_q;
  logic              redir_c, bad_c, buf_load_c, buf_flush_c;

  // Once trapped, further redirects are ignored so the faulting target stays visible.
  assign redir_c = redirect_valid_i & ~mis_q;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  assign tgt_c = redirect_pc_i;
  assign bad_c = redir_c & (|redirect_pc_i[1:0]);
`else
  assign tgt_c = redirect_pc_i & ~AWIDTH'(INSN_BYTES - 1);
  assign bad_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= BASEADDR;
      mis_q       <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mis_q       <= mis_d;
      req_valid_q <= (state_d == REQ);
    end
  end

  // Next state, PC update and buffer control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mis_d       = mis_q | bad_c;
    buf_load_c  = 1'b0;
    buf_flush_c = 1'b0;
    if (redir_c) pc_d = tgt_c;
    case (state_q)
      IDLE: state_d = bad_c ? HALT : REQ;
      REQ: begin
        if (redir_c) begin
          if (imem_req_ready_i) state_d = DRAIN;
          else                  state_d = bad_c ? HALT : REQ;
        end else if (imem_req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redir_c) begin
          state_d = imem_rsp_valid_i ? (bad_c ? HALT : REQ) : DRAIN;
        end else if (imem_rsp_valid_i) begin
          buf_load_c = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (redir_c) begin
          buf_flush_c = 1'b1;
          state_d     = bad_c ? HALT : REQ;
        end else if (insn_ready_i) begin
          pc_d    = pc_q + AWIDTH'(INSN_BYTES);
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid_i) state_d = (mis_q || bad_c) ? HALT : REQ;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  fetch_buf #(.W(DWIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load_c),
    .flush (buf_flush_c),
    .ready (insn_ready_i),
    .data  (imem_rsp_data_i),
    .valid (insn_valid_o),
    .q     (insn_o)
  );

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = pc_q;
  assign pc_o             = pc_q;
  assign misalign_o       = mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl, with a second instance for PC wrap.
module tb_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic        misalign_o;

  logic        w_req_valid, w_rsp_valid, w_insn_valid, w_misalign;
  logic [31:0] w_req_addr, w_insn, w_pc;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .insn_o(insn_o),
    .pc_o(pc_o), .misalign_o(misalign_o)
  );

  fetch_ctrl #(.BASEADDR(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_valid_o(w_req_valid), .imem_req_addr_o(w_req_addr),
    .imem_req_ready_i(1'b1),
    .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(32'h13),
    .insn_valid_o(w_insn_valid), .insn_ready_i(1'b1), .insn_o(w_insn),
    .pc_o(w_pc), .misalign_o(w_misalign)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] req_log[$];
  logic [31:0] req_log2[$];
  logic [31:0] dpc[$];
  logic [31:0] dinsn[$];
  int          dcyc[$];

  // Memory model state: one outstanding request, response mem_delay cycles later.
  int          mem_delay = 1;
  logic        pending   = 1'b0;
  logic [31:0] paddr     = '0;
  int          cnt       = 0;

  // Advance one clock: log handshakes at the edge, then update the memory model at negedge.
  task automatic tick();
    logic hs, rsp, dl, hs2;
    logic [31:0] a, p, d, a2;
    hs  = imem_req_valid_o && imem_req_ready_i;
    a   = imem_req_addr_o;
    rsp = imem_rsp_valid_i;
    dl  = insn_valid_o && insn_ready_i;
    p   = pc_o;
    d   = insn_o;
    hs2 = w_req_valid;
    a2  = w_req_addr;
    @(posedge clk);
    cyc++;
    if (hs)  req_log.push_back(a);
    if (hs2) req_log2.push_back(a2);
    if (dl) begin
      dpc.push_back(p);
      dinsn.push_back(d);
      dcyc.push_back(cyc);
    end
    @(negedge clk);
    if (rsp) pending = 1'b0;
    if (hs) begin
      pending = 1'b1;
      paddr   = a;
      cnt     = mem_delay - 1;
    end else if (pending && cnt > 0) begin
      cnt--;
    end
    imem_rsp_valid_i = pending && (cnt == 0);
    imem_rsp_data_i  = ~paddr;
    w_rsp_valid      = hs2;
  endtask

  task automatic clear_logs();
    req_log.delete();
    dpc.delete();
    dinsn.delete();
    dcyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    insn_ready_i     = 1'b0;
    w_rsp_valid      = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({imem_req_valid_o, insn_valid_o, misalign_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got req/insn/mis=%b required 000",
               {imem_req_valid_o, insn_valid_o, misalign_o});
    end
    n_cmp++;
    if (pc_o !== BASE || imem_req_addr_o !== BASE) begin
      n_err++;
      $display("FAIL reset_pc: got pc=%h addr=%h required %h", pc_o, imem_req_addr_o, BASE);
    end
    n_cmp++;
    if (insn_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_insn: got %h required 00000000", insn_o);
    end
    n_cmp++;
    if (w_pc !== 32'hFFFFFFFC) begin
      n_err++;
      $display("FAIL reset_pc_wrap_inst: got %h required fffffffc", w_pc);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== BASE) begin
      n_err++;
      $display("FAIL first_req: got valid=%b addr=%h required 1 %h",
               imem_req_valid_o, imem_req_addr_o, BASE);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] exp;
    imem_req_ready_i = 1'b1;
    insn_ready_i     = 1'b1;
    clear_logs();
    for (int i = 0; i < 30 && dpc.size() < 3; i++) tick();
    n_cmp++;
    if (dpc.size() != 3) begin
      n_err++;
      $display("FAIL seq_count: got %0d deliveries required 3", dpc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp = BASE + 32'(4 * i);
        n_cmp++;
        if (req_log[i] !== exp || dpc[i] !== exp || dinsn[i] !== ~exp) begin
          n_err++;
          $display("FAIL seq_item%0d: got req=%h pc=%h insn=%h required %h %h %h",
                   i, req_log[i], dpc[i], dinsn[i], exp, exp, ~exp);
        end
      end
      n_cmp++;
      if (dcyc[1] - dcyc[0] != 3 || dcyc[2] - dcyc[1] != 3) begin
        n_err++;
        $display("FAIL seq_rate: got spacing %0d,%0d required 3,3",
                 dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hpc, hinsn;
    int nreq;
    insn_ready_i = 1'b0;
    for (int i = 0; i < 20 && !insn_valid_o; i++) tick();
    hpc   = pc_o;
    hinsn = insn_o;
    n_cmp++;
    if (insn_valid_o !== 1'b1 || hpc !== BASE + 32'd12 || hinsn !== ~(BASE + 32'd12)) begin
      n_err++;
      $display("FAIL bp_enter: got valid=%b pc=%h insn=%h required 1 %h %h",
               insn_valid_o, hpc, hinsn, BASE + 32'd12, ~(BASE + 32'd12));
    end
    nreq = req_log.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({pc_o, insn_o, imem_req_valid_o, insn_valid_o} !== {hpc, hinsn, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got pc=%h insn=%h req=%b vld=%b required %h %h 0 1",
                 i, pc_o, insn_o, imem_req_valid_o, insn_valid_o, hpc, hinsn);
      end
    end
    n_cmp++;
    if (req_log.size() != nreq) begin
      n_err++;
      $display("FAIL bp_noreq: got %0d requests required %0d", req_log.size(), nreq);
    end
    insn_ready_i = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== BASE + 32'd16 || insn_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got req=%b addr=%h vld=%b required 1 %h 0",
               imem_req_valid_o, imem_req_addr_o, insn_valid_o, BASE + 32'd16);
    end
  endtask

  task automatic test_redirect_wait();
    mem_delay = 4;
    for (int i = 0; i < 20 && !imem_req_valid_o; i++) tick();
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h01000100;
    tick();
    redirect_valid_i = 1'b0;
    clear_logs();
    n_cmp++;
    if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h01000100) begin
      n_err++;
      $display("FAIL rw_drain: got req=%b addr=%h required 0 01000100",
               imem_req_valid_o, imem_req_addr_o);
    end
    for (int i = 0; i < 40 && dpc.size() == 0; i++) tick();
    mem_delay = 1;
    n_cmp++;
    if (dpc.size() != 1 || req_log.size() < 1) begin
      n_err++;
      $display("FAIL rw_timeout: got %0d deliveries %0d requests required 1 1",
               dpc.size(), req_log.size());
    end else begin
      n_cmp++;
      if (req_log[0] !== 32'h01000100 || dpc[0] !== 32'h01000100 || dinsn[0] !== ~32'h01000100) begin
        n_err++;
        $display("FAIL rw_path: got req=%h pc=%h insn=%h required 01000100 01000100 %h",
                 req_log[0], dpc[0], dinsn[0], ~32'h01000100);
      end
    end
  endtask

  task automatic test_same_cycle();
    clear_logs();
    for (int i = 0; i < 20 && !imem_req_valid_o; i++) tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h01000200;
    tick();
    redirect_valid_i = 1'b0;
    n_cmp++;
    if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h01000200) begin
      n_err++;
      $display("FAIL sc_req_drain: got req=%b addr=%h required 0 01000200",
               imem_req_valid_o, imem_req_addr_o);
    end
    tick();
    n_cmp++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h01000200 || insn_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL sc_drain_exit: got req=%b addr=%h vld=%b required 1 01000200 0",
               imem_req_valid_o, imem_req_addr_o, insn_valid_o);
    end
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h01000300;
    tick();
    redirect_valid_i = 1'b0;
    n_cmp++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h01000300 || insn_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL sc_rsp_drop: got req=%b addr=%h vld=%b required 1 01000300 0",
               imem_req_valid_o, imem_req_addr_o, insn_valid_o);
    end
    tick();
    tick();
    n_cmp++;
    if (insn_valid_o !== 1'b1 || pc_o !== 32'h01000300 || insn_o !== ~32'h01000300) begin
      n_err++;
      $display("FAIL sc_out: got vld=%b pc=%h insn=%h required 1 01000300 %h",
               insn_valid_o, pc_o, insn_o, ~32'h01000300);
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h01000400;
    tick();
    redirect_valid_i = 1'b0;
    n_cmp++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h01000400 || insn_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL sc_out_redir: got req=%b addr=%h vld=%b required 1 01000400 0",
               imem_req_valid_o, imem_req_addr_o, insn_valid_o);
    end
    n_cmp++;
    if (dpc.size() != 1 || dpc[0] !== 32'h01000300) begin
      n_err++;
      $display("FAIL sc_consumed: got %0d deliveries required 1 at 01000300", dpc.size());
    end
  endtask

  task automatic test_misalign();
    int nreq;
    for (int i = 0; i < 20 && !imem_req_valid_o; i++) tick();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h01000102;
    tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    n_cmp++;
    if (misalign_o !== 1'b1 || imem_req_valid_o !== 1'b0 || pc_o !== 32'h01000102) begin
      n_err++;
      $display("FAIL mis_trap: got mis=%b req=%b pc=%h required 1 0 01000102",
               misalign_o, imem_req_valid_o, pc_o);
    end
    nreq = req_log.size();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h01000500;
    tick();
    redirect_valid_i = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (req_log.size() != nreq || imem_req_valid_o !== 1'b0 || pc_o !== 32'h01000102 || misalign_o !== 1'b1) begin
      n_err++;
      $display("FAIL mis_halt: got reqs=%0d req=%b pc=%h mis=%b required %0d 0 01000102 1",
               req_log.size(), imem_req_valid_o, pc_o, misalign_o, nreq);
    end
`else
    n_cmp++;
    if (misalign_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h01000100) begin
      n_err++;
      $display("FAIL mis_align: got mis=%b req=%b addr=%h required 0 1 01000100",
               misalign_o, imem_req_valid_o, imem_req_addr_o);
    end
    nreq = req_log.size();
    tick();
    n_cmp++;
    if (req_log.size() != nreq + 1 || req_log[nreq] !== 32'h01000100 || misalign_o !== 1'b0) begin
      n_err++;
      $display("FAIL mis_issue: got reqs=%0d mis=%b required %0d 0 at 01000100",
               req_log.size(), misalign_o, nreq + 1);
    end
`endif
  endtask

  task automatic test_wrap();
    n_cmp++;
    if (req_log2.size() < 2) begin
      n_err++;
      $display("FAIL wrap_count: got %0d requests required at least 2", req_log2.size());
    end else begin
      n_cmp++;
      if (req_log2[0] !== 32'hFFFFFFFC || req_log2[1] !== 32'h00000000) begin
        n_err++;
        $display("FAIL wrap_addr: got %h %h required fffffffc 00000000",
                 req_log2[0], req_log2[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect_wait();
    test_same_cycle();
    test_misalign();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
